fetch_unit: RTL

Instruction fetch stage of the 5-stage RISC-V pipeline: owns the PC register, drives a single-outstanding instruction-memory request port, and loads the IF/ID pipeline register. It is the consumer of the hazard unit's fetch-side controls (`hazard_fe_enable`, `hazard_if_id_clear`) and of the EX-stage branch/jump redirect. A small state machine buffers responses that arrive during a stall and discards responses made stale by a redirect.

---
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, single-outstanding imem request port, IF/ID register.
// Optional `FETCH_PERF_CNT_EN adds stall/flush performance counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        hazard_fe_enable,
   input  logic        hazard_if_id_clear,
   input  logic        ex_redirect_en,
   input  logic [31:0] ex_redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        if_id_valid,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc,
   output logic [31:0] if_id_pc_plus4,
   output logic        fetch_busy,
   output logic [2:0]  dbg_state
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cycles,
   output logic [31:0] perf_flush_count
`endif
);

   // Handshake: imem_req is a one-cycle strobe, accepted in the cycle it is high;
   // imem_rvalid qualifies imem_rdata for exactly one cycle per accepted request.
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_HOLD  = 3'd3;
   localparam logic [2:0] S_KILL  = 3'd4;

   logic [2:0]  r_state;
   logic [31:0] r_pc;
   logic [31:0] r_buf;
   logic        r_if_id_valid;
   logic [31:0] r_if_id_instr;
   logic [31:0] r_if_id_pc;

   logic [2:0]  w_next_state;
   logic [31:0] w_next_pc;
   logic        w_req;
   logic [31:0] w_addr;
   logic        w_buf_load;
   logic        w_avail;
   logic [31:0] w_avail_instr;
   logic        w_consume;
   logic [31:0] w_pc_plus4;

   assign w_pc_plus4    = r_pc + 32'd4;
   assign w_avail       = ((r_state == S_WAIT) && imem_rvalid) || (r_state == S_HOLD);
   assign w_avail_instr = (r_state == S_HOLD) ? r_buf : imem_rdata;
   assign w_consume     = !ex_redirect_en && !hazard_if_id_clear && hazard_fe_enable && w_avail;

   always_comb begin
      w_next_state = r_state;
      w_next_pc    = r_pc;
      w_req        = 1'b0;
      w_addr       = r_pc;
      w_buf_load   = 1'b0;
      case (r_state)
         S_IDLE: w_next_state = S_FETCH;
         S_FETCH: begin
            w_req        = 1'b1;
            w_addr       = ex_redirect_en ? ex_redirect_pc : r_pc;
            w_next_pc    = w_addr;
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (!imem_rvalid) begin
               if (ex_redirect_en) begin
                  w_next_pc    = ex_redirect_pc;
                  w_next_state = S_KILL;
               end
            end else if (ex_redirect_en) begin
               w_req     = 1'b1;
               w_addr    = ex_redirect_pc;
               w_next_pc = ex_redirect_pc;
            end else if (w_consume) begin
               w_req     = 1'b1;
               w_addr    = w_pc_plus4;
               w_next_pc = w_pc_plus4;
            end else begin
               w_buf_load   = 1'b1;
               w_next_state = S_HOLD;
            end
         end
         S_HOLD: begin
            if (ex_redirect_en) begin
               w_req        = 1'b1;
               w_addr       = ex_redirect_pc;
               w_next_pc    = ex_redirect_pc;
               w_next_state = S_WAIT;
            end else if (w_consume) begin
               w_req        = 1'b1;
               w_addr       = w_pc_plus4;
               w_next_pc    = w_pc_plus4;
               w_next_state = S_WAIT;
            end
         end
         S_KILL: begin
            // The stale response is dropped; the refetch follows the newest redirect.
            if (ex_redirect_en) w_next_pc = ex_redirect_pc;
            if (imem_rvalid) begin
               w_req        = 1'b1;
               w_addr       = ex_redirect_en ? ex_redirect_pc : r_pc;
               w_next_pc    = w_addr;
               w_next_state = S_WAIT;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_buf   <= 32'd0;
      end else begin
         r_state <= w_next_state;
         r_pc    <= w_next_pc;
         if (w_buf_load) r_buf <= imem_rdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_if_id_valid <= 1'b0;
         r_if_id_instr <= NOP_INSTR;
         r_if_id_pc    <= 32'd0;
      end else if (ex_redirect_en || hazard_if_id_clear) begin
         r_if_id_valid <= 1'b0;
         r_if_id_instr <= NOP_INSTR;
      end else if (hazard_fe_enable) begin
         if (w_avail) begin
            r_if_id_valid <= 1'b1;
            r_if_id_instr <= w_avail_instr;
            r_if_id_pc    <= r_pc;
         end else begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_flush_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= 32'd0;
         r_flush_cnt <= 32'd0;
      end else begin
         if (!hazard_fe_enable) r_stall_cnt <= r_stall_cnt + 32'd1;
         if (ex_redirect_en)    r_flush_cnt <= r_flush_cnt + 32'd1;
      end
   end

   assign perf_stall_cycles = r_stall_cnt;
   assign perf_flush_count  = r_flush_cnt;
`endif

   assign imem_req       = w_req;
   assign imem_addr      = w_addr;
   assign if_id_valid    = r_if_id_valid;
   assign if_id_instr    = r_if_id_instr;
   assign if_id_pc       = r_if_id_pc;
   assign if_id_pc_plus4 = r_if_id_pc + 32'd4;
   assign fetch_busy     = (r_state == S_FETCH) || (r_state == S_KILL) ||
                           ((r_state == S_WAIT) && !imem_rvalid);
   assign dbg_state      = r_state;

endmodule
